kfmmc_card_command_responder: RTL
=================================

// Module: kfmmc_card_command_responder
// PURPOSE
//  Card-side end of the MMC CMD line: decodes 48-bit host command frames, presents them to card-model
//  logic, then serialises a 48-bit response with generated CRC7 back to the host. Pairs with the host
//  drive in bench and loopback builds. Runs entirely on the system clock; mmc_clk is an input sampled as data.
// PARAMETERS
//  ncr_cycles        8'd002          mmc_clk falling edges between command end bit and response start bit (2..64)
//  response_timeout  32'h0000FFFF    clocks to wait for response_valid before abandoning the command
// PORTS
//  clock             in   1   system clock
//  reset             in   1   asynchronous, active-high reset
//  mmc_clk           in   1   host MMC clock (asynchronous to clock)
//  mmc_cmd_in        in   1   CMD line input
//  mmc_cmd_out       out  1   CMD line drive value
//  mmc_cmd_io        out  1   1 = line released (input), 0 = responder drives mmc_cmd_out
//  command_valid     out  1   one-clock pulse: command fields valid
//  command_index     out  6   received command index
//  command_argument  out  32  received argument
//  command_crc_error out  1   CRC7 mismatch on the frame reported with command_valid
//  frame_error       out  1   one-clock pulse: transmission bit or end bit wrong; frame discarded
//  response_valid    in   1   card logic supplies response (accepted only in WAIT_RESPONSE)
//  no_response       in   1   with response_valid: send nothing, return to IDLE
//  response_index    in   6   response index field
//  response_payload  in   32  response body
//  responder_busy    out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: mmc_cmd_out=1, mmc_cmd_io=1, all pulses 0, command fields 0, busy 0, state IDLE.
//  Sampling: mmc_clk and mmc_cmd_in each pass a 2-flop synchroniser (same depth, so they stay aligned).
//   Edge detect compares the sync'd clock with its previous value. Rise = sample CMD; fall = update CMD drive.
//   mmc_clk high and low phases must each be >=4 clocks.
//  Frame: bit47 start=0, bit46 transmission=1, [45:40] index, [39:8] argument, [7:1] CRC7, bit0 end=1. MSB first.
//  CRC7: poly x^7+x^3+1, init 0, over bits 47..8; same generator for response bits 47..8.
//  FSM:
//   IDLE: on rise with CMD=0, capture start bit, bit count=1 -> RECEIVE.
//   RECEIVE: shift one bit per rise; after 48th bit -> CHECK.
//   CHECK (1 clock): bit46!=1 or bit0!=1 -> pulse frame_error -> IDLE. Otherwise pulse command_valid with
//    index/argument/crc_error (fields held until next command_valid) -> WAIT_RESPONSE.
//   WAIT_RESPONSE: response_valid & no_response -> IDLE; response_valid -> latch 48-bit response
//    {0,0,index,payload,CRC7,1}, load ncr counter -> NCR_GAP. Timer reaching response_timeout -> IDLE.
//    Timer starts at 0 on entry and counts every clock.
//   NCR_GAP: decrement per fall, line still released; at 0 (the ncr_cycles-th fall) also drive bit47:
//    mmc_cmd_io=0, mmc_cmd_out=0 -> SEND.
//   SEND: each further fall drives next bit; after bit0 driven, next fall releases line (io=1, out=1) -> IDLE.
//  Outputs are registered; drive changes one clock after the synchronised falling edge is detected.
//  response_valid outside WAIT_RESPONSE is ignored. CRC-error commands are still reported; card logic decides.
//  Host restarting mid-frame is not detected; frame is decoded as received and CHECK filters it.
//  Reset mid-operation: immediate release of line, state IDLE, partial frame discarded.
//  mmc_clk stopping: state holds indefinitely (no timeout outside WAIT_RESPONSE).
// TESTING
//  CMD0 bytes 40 00 00 00 00 95 -> command_valid, index=0, arg=0, crc_error=0; no_response=1 -> line never driven.
//  CMD8 bytes 48 00 00 01 AA 87, reply index=8 payload=0x000001AA -> CMD shows 08 00 00 01 AA 13,
//   start bit on 2nd fall after end bit.
//  CMD8 with CRC byte 0x85 -> command_valid with crc_error=1; fields still index=8, arg=0x000001AA.
//  Frame with end bit 0 (last byte 0x94) -> frame_error pulse, no command_valid, returns IDLE.
//  No response_valid for response_timeout clocks -> IDLE, line released; next CMD0 decoded normally.
//  Reset asserted during SEND bit 20 -> mmc_cmd_io=1, mmc_cmd_out=1 next clock; busy=0.

Source files
------------

// File: rtl/kfmmc_card_command_responder.sv
// Card-side MMC CMD line responder: receives 48-bit host command frames,
// reports them to card logic, and returns a 48-bit response with CRC7.
// Everything runs on the system clock; mmc_clk is sampled as data.
module kfmmc_card_command_responder #(
  parameter logic [7:0]  ncr_cycles       = 8'd2,
  parameter logic [31:0] response_timeout = 32'h0000FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mmc_clk,
  input  logic        mmc_cmd_in,
  output logic        mmc_cmd_out,
  output logic        mmc_cmd_io,
  output logic        command_valid,
  output logic [5:0]  command_index,
  output logic [31:0] command_argument,
  output logic        command_crc_error,
  output logic        frame_error,
  input  logic        response_valid,
  input  logic        no_response,
  input  logic [5:0]  response_index,
  input  logic [31:0] response_payload,
  output logic        responder_busy
);

  typedef enum logic [2:0] {
    IDLE,
    RECEIVE,
    CHECK,
    WAIT_RESPONSE,
    NCR_GAP,
    SEND
  } state_t;

  state_t       state_q;
  logic         clk_meta_q, clk_sync_q, clk_prev_q;
  logic         cmd_meta_q, cmd_sync_q;
  logic         mmc_rise, mmc_fall;
  logic [47:0]  rx_q;
  logic [5:0]   rx_cnt_q;
  logic [47:0]  resp_q;
  logic [5:0]   tx_bit_q;
  logic [7:0]   ncr_q;
  logic [31:0]  timer_q;
  logic [6:0]   rx_crc_d;
  logic [6:0]   tx_crc_d;

  // CRC7, polynomial x^7 + x^3 + 1, zero init, MSB first over 40 bits.
  function automatic logic [6:0] crc7_of(input logic [39:0] data);
    logic [6:0]  c;
    logic [39:0] d;
    logic        fb;
    c = '0;
    d = data;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = d[39] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
      d  = {d[38:0], 1'b0};
    end
    return c;
  endfunction

  // Two-flop synchronisers of equal depth keep clock and data aligned;
  // they reset to the idle line levels so no spurious edge follows reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      cmd_meta_q <= 1'b1;
      cmd_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= mmc_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      cmd_meta_q <= mmc_cmd_in;
      cmd_sync_q <= cmd_meta_q;
    end
  end

  // Edge detection and CRC generation for received and outgoing frames.
  always_comb begin
    mmc_rise = clk_sync_q & ~clk_prev_q;
    mmc_fall = ~clk_sync_q & clk_prev_q;
    rx_crc_d = crc7_of(rx_q[47:8]);
    tx_crc_d = crc7_of({2'b00, response_index, response_payload});
  end

  assign responder_busy = (state_q != IDLE);

  // Protocol FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      rx_q              <= '0;
      rx_cnt_q          <= '0;
      resp_q            <= '0;
      tx_bit_q          <= '0;
      ncr_q             <= '0;
      timer_q           <= '0;
      mmc_cmd_out       <= 1'b1;
      mmc_cmd_io        <= 1'b1;
      command_valid     <= 1'b0;
      frame_error       <= 1'b0;
      command_index     <= '0;
      command_argument  <= '0;
      command_crc_error <= 1'b0;
    end else begin
      command_valid <= 1'b0;
      frame_error   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mmc_rise && !cmd_sync_q) begin
            rx_q     <= {rx_q[46:0], cmd_sync_q};
            rx_cnt_q <= 6'd1;
            state_q  <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (mmc_rise) begin
            rx_q     <= {rx_q[46:0], cmd_sync_q};
            rx_cnt_q <= rx_cnt_q + 6'd1;
            if (rx_cnt_q == 6'd47) state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!rx_q[46] || !rx_q[0]) begin
            frame_error <= 1'b1;
            state_q     <= IDLE;
          end else begin
            command_valid     <= 1'b1;
            command_index     <= rx_q[45:40];
            command_argument  <= rx_q[39:8];
            command_crc_error <= (rx_crc_d != rx_q[7:1]);
            timer_q           <= '0;
            state_q           <= WAIT_RESPONSE;
          end
        end
        WAIT_RESPONSE: begin
          if (response_valid) begin
            if (no_response) begin
              state_q <= IDLE;
            end else begin
              resp_q  <= {2'b00, response_index, response_payload, tx_crc_d, 1'b1};
              ncr_q   <= ncr_cycles;
              state_q <= NCR_GAP;
            end
          end else if (timer_q == response_timeout) begin
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        NCR_GAP: begin
          // The fall that brings the count to zero also drives the start bit.
          if (mmc_fall) begin
            if (ncr_q <= 8'd1) begin
              mmc_cmd_io  <= 1'b0;
              mmc_cmd_out <= resp_q[47];
              tx_bit_q    <= 6'd47;
              ncr_q       <= '0;
              state_q     <= SEND;
            end else begin
              ncr_q <= ncr_q - 8'd1;
            end
          end
        end
        SEND: begin
          if (mmc_fall) begin
            if (tx_bit_q == 6'd0) begin
              mmc_cmd_io  <= 1'b1;
              mmc_cmd_out <= 1'b1;
              state_q     <= IDLE;
            end else begin
              mmc_cmd_out <= resp_q[tx_bit_q - 6'd1];
              tx_bit_q    <= tx_bit_q - 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
